// File: rtl/uart_word_packer.sv
// Packs UART byte strobes into 32-bit words and queues them in a small FIFO for a valid/ready consumer.
// Define UART_PACKER_BIG_ENDIAN_EN to place the first byte in word[31:24] instead of word[7:0].
module uart_word_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    output logic                          word_valid,
    output logic [31:0]                   word_data,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          partial_drop
);
    localparam int LW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    logic [1:0]    index_reg;
    logic [31:0]   shift_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [LW-1:0] rd_ptr_reg;
    logic [LW-1:0] wr_ptr_reg;
    logic [LW:0]   level_reg;
    logic          overflow_reg;
    logic          partial_drop_reg;

    logic [1:0]    lane_sel;
    logic [31:0]   word_next;
    logic          complete;
    logic          full;
    logic          pop;
    logic          push;
    logic          expire;

`ifdef UART_PACKER_BIG_ENDIAN_EN
    assign lane_sel = 2'd3 - index_reg;
`else
    assign lane_sel = index_reg;
`endif

    // The incoming byte is merged into its lane so a completed word can be pushed on the 4th byte's cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_next[8*gi +: 8] = (lane_sel == 2'(gi)) ? byte_data : shift_reg[8*gi +: 8];
        end
    endgenerate

    assign complete = byte_valid & (index_reg == 2'd3);
    assign full     = (level_reg == (LW+1)'(FIFO_DEPTH));
    assign pop      = word_valid & word_ready;
    assign push     = complete & (~full | pop);
    assign expire   = (index_reg != 2'd0) & ~byte_valid & (count_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_reg        <= 2'd0;
            shift_reg        <= '0;
            count_reg        <= '0;
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            level_reg        <= '0;
            overflow_reg     <= 1'b0;
            partial_drop_reg <= 1'b0;
        end else begin
            if (byte_valid) begin
                index_reg <= index_reg + 2'd1;
                shift_reg <= complete ? '0 : word_next;
                count_reg <= '0;
            end else if (expire) begin
                index_reg <= 2'd0;
                shift_reg <= '0;
                count_reg <= '0;
            end else if (index_reg != 2'd0) begin
                count_reg <= count_reg + CW'(1);
            end else begin
                count_reg <= '0;
            end
            partial_drop_reg <= expire;

            if (push) wr_ptr_reg <= wr_ptr_reg + LW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + LW'(1);
            if (push && !pop)      level_reg <= level_reg + (LW+1)'(1);
            else if (pop && !push) level_reg <= level_reg - (LW+1)'(1);

            // A fresh drop outranks a clear arriving in the same cycle.
            if (complete && full && !pop) overflow_reg <= 1'b1;
            else if (clr_overflow)        overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= word_next;
    end

    assign word_valid   = (level_reg != '0);
    assign word_data    = word_valid ? mem[rd_ptr_reg] : '0;
    assign fifo_level   = level_reg;
    assign overflow     = overflow_reg;
    assign partial_drop = partial_drop_reg;
endmodule

// File: tb/tb_uart_word_packer.sv
// Directed self-checking bench for uart_word_packer (default FIFO_DEPTH=4, TIMEOUT=64).
module tb_uart_word_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        clr_overflow = 1'b0;
    logic        partial_drop;

    int checks = 0;
    int failures = 0;

    uart_word_packer dut (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .fifo_level(fifo_level), .overflow(overflow), .clr_overflow(clr_overflow),
        .partial_drop(partial_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w4(input logic [7:0] b0, b1, b2, b3);
`ifdef UART_PACKER_BIG_ENDIAN_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the byte is taken on the following posedge and we return at the next negedge.
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
        $display("byte %h -> valid=%0b level=%0d ovf=%0b", b, word_valid, fifo_level, overflow);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_data", word_data, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(partial_drop), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word with consumer ready
        word_ready = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("t1_not_yet", 32'(word_valid), 32'd0);
        send_byte(8'h44);
        chk("t1_valid", 32'(word_valid), 32'd1);
        chk("t1_data", word_data, w4(8'h11, 8'h22, 8'h33, 8'h44));
        @(negedge clk);
        chk("t1_valid_gone", 32'(word_valid), 32'd0);
        chk("t1_level0", 32'(fifo_level), 32'd0);

        // Fill and overflow
        word_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("t2_level4", 32'(fifo_level), 32'd4);
        chk("t2_no_ovf", 32'(overflow), 32'd0);
        for (int i = 16; i < 20; i++) send_byte(8'(i));
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_level_still4", 32'(fifo_level), 32'd4);
        word_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_pop_valid", 32'(word_valid), 32'd1);
            chk("t2_pop_data", word_data, w4(8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)));
            $display("pop %0d data=%h", k, word_data);
            @(negedge clk);
        end
        chk("t2_drained", 32'(word_valid), 32'd0);
        chk("t2_level0", 32'(fifo_level), 32'd0);

        // Timeout discards a partial word
        send_byte(8'hAA); send_byte(8'hBB);
        for (int i = 0; i < 63; i++) begin
            chk("t3_no_early_drop", 32'(partial_drop), 32'd0);
            @(negedge clk);
        end
        @(negedge clk);
        chk("t3_drop", 32'(partial_drop), 32'd1);
        chk("t3_no_word", 32'(word_valid), 32'd0);
        @(negedge clk);
        chk("t3_drop_pulse", 32'(partial_drop), 32'd0);
        word_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("t3_word", word_data, w4(8'h01, 8'h02, 8'h03, 8'h04));
        chk("t3_level1", 32'(fifo_level), 32'd1);
        word_ready = 1'b1;
        @(negedge clk);
        chk("t3_level0", 32'(fifo_level), 32'd0);

        // A byte on the expiry cycle wins over the timeout
        send_byte(8'h55);
        repeat (63) @(negedge clk);
        send_byte(8'h66);
        chk("t3b_no_drop", 32'(partial_drop), 32'd0);
        send_byte(8'h77);
        chk("t3b_no_drop2", 32'(partial_drop), 32'd0);
        word_ready = 1'b0;
        send_byte(8'h88);
        chk("t3b_word", word_data, w4(8'h55, 8'h66, 8'h77, 8'h88));
        word_ready = 1'b1;
        @(negedge clk);
        chk("t3b_level0", 32'(fifo_level), 32'd0);

        // Clear the sticky overflow from the fill test
        word_ready = 1'b0;
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Push and pop together at full
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
        chk("t4_full", 32'(fifo_level), 32'd4);
        send_byte(8'h30); send_byte(8'h31); send_byte(8'h32);
        word_ready = 1'b1;
        send_byte(8'h33);
        word_ready = 1'b0;
        chk("t4_level4", 32'(fifo_level), 32'd4);
        chk("t4_no_ovf", 32'(overflow), 32'd0);
        chk("t4_head", word_data, w4(8'h24, 8'h25, 8'h26, 8'h27));

        // Overflow set wins over a same-cycle clear
        send_byte(8'h40); send_byte(8'h41); send_byte(8'h42);
        clr_overflow = 1'b1;
        send_byte(8'h43);
        clr_overflow = 1'b0;
        chk("t6_set_wins", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("t6_cleared", 32'(overflow), 32'd0);
        chk("t6_level4", 32'(fifo_level), 32'd4);

        // Reset mid-word with two words queued
        word_ready = 1'b1;
        repeat (2) @(negedge clk);
        word_ready = 1'b0;
        chk("t5_level2", 32'(fifo_level), 32'd2);
        send_byte(8'h50); send_byte(8'h51);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(word_valid), 32'd0);
        chk("t5_data", word_data, 32'd0);
        chk("t5_level", 32'(fifo_level), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_drop", 32'(partial_drop), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h60); send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
        chk("t5_one_word", 32'(fifo_level), 32'd1);
        chk("t5_word", word_data, w4(8'h60, 8'h61, 8'h62, 8'h63));
        word_ready = 1'b1;
        @(negedge clk);
        chk("t5_empty", 32'(word_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
